// File: rtl/line_drawing_core.sv
// Bresenham line rasteriser: latches two endpoints on start, then emits one frame-buffer pixel write per cycle.
// Pixels outside the 640x480 screen are stepped through but not written. A sticky finish flag marks the end of the line.
module line_drawing_core #(
  parameter int WIDTH  = 13,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  x0,
  input  logic [WIDTH-1:0]  y0,
  input  logic [WIDTH-1:0]  x1,
  input  logic [WIDTH-1:0]  y1,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_addr,
  output logic              color_out,
  output logic              sys_finish
);

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  localparam logic [WIDTH-1:0] H_LIM = WIDTH'(H_RES);
  localparam logic [WIDTH-1:0] V_LIM = WIDTH'(V_RES);
  localparam logic signed [WIDTH+1:0] ERR_ZERO = '0;

  state_t r_state, w_next;

  logic [WIDTH-1:0]        r_x0, r_y0, r_x1, r_y1, r_x, r_y;
  logic signed [WIDTH+1:0] r_dx, r_dy, r_err;
  logic                    r_sx_neg, r_sy_neg;

  logic [WIDTH-1:0]        w_dx_abs, w_dy_abs, w_x_nxt, w_y_nxt;
  logic signed [WIDTH+2:0] w_e2;
  logic signed [WIDTH+1:0] w_err_nxt;
  logic                    w_step_x, w_step_y, w_at_end, w_visible;
  logic [ADDR_W-1:0]       w_yw, w_addr;

  assign w_dx_abs  = (r_x1 > r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_dy_abs  = (r_y1 > r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

  // e2 needs one extra bit over err so doubling never overflows
  assign w_e2      = $signed({r_err, 1'b0});
  assign w_step_x  = (w_e2 >= r_dy);
  assign w_step_y  = (w_e2 <= r_dx);
  assign w_err_nxt = r_err + (w_step_x ? r_dy : ERR_ZERO) + (w_step_y ? r_dx : ERR_ZERO);
  assign w_x_nxt   = w_step_x ? (r_sx_neg ? r_x - 1'b1 : r_x + 1'b1) : r_x;
  assign w_y_nxt   = w_step_y ? (r_sy_neg ? r_y - 1'b1 : r_y + 1'b1) : r_y;

  assign w_at_end  = (r_x == r_x1) && (r_y == r_y1);
  assign w_visible = (r_x < H_LIM) && (r_y < V_LIM);

  // y*640 as shift-and-add
  assign w_yw      = ADDR_W'(r_y);
  assign w_addr    = (w_yw << 9) + (w_yw << 7) + ADDR_W'(r_x);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = INIT;
      INIT:    w_next = DRAW;
      DRAW:    if (w_at_end) w_next = DONE;
      DONE:    if (start) w_next = INIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_err      <= '0;
      r_sx_neg   <= 1'b0;
      r_sy_neg   <= 1'b0;
      FB_WE      <= 1'b0;
      FB_addr    <= '0;
      color_out  <= 1'b0;
      sys_finish <= 1'b0;
    end else begin
      r_state   <= w_next;
      FB_WE     <= 1'b0;
      color_out <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_x0       <= x0;
            r_y0       <= y0;
            r_x1       <= x1;
            r_y1       <= y1;
            sys_finish <= 1'b0;
          end else if (r_state == DONE) begin
            sys_finish <= 1'b1;
          end
        end
        INIT: begin
          r_dx     <= $signed({2'b00, w_dx_abs});
          r_dy     <= -$signed({2'b00, w_dy_abs});
          r_err    <= $signed({2'b00, w_dx_abs}) - $signed({2'b00, w_dy_abs});
          r_sx_neg <= !(r_x0 < r_x1);
          r_sy_neg <= !(r_y0 < r_y1);
          r_x      <= r_x0;
          r_y      <= r_y0;
        end
        DRAW: begin
          // off-screen pixels still consume a cycle but leave the address untouched
          if (w_visible) begin
            FB_WE     <= 1'b1;
            color_out <= 1'b1;
            FB_addr   <= w_addr;
          end
          if (!w_at_end) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_err <= w_err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_drawing_core.sv
// Directed bench for line_drawing_core: draws hand-computed lines and checks write addresses, counts and timing.
module tb_line_drawing_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic        color_out;
  logic        sys_finish;

  int total = 0;
  int bad   = 0;
  int addrs[$];
  int first_cyc, last_cyc, fin_cyc, bad_col;

  always #5 clk = ~clk;

  line_drawing_core #(.WIDTH(13), .H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .FB_WE      (fb_we),
    .FB_addr    (fb_addr),
    .color_out  (color_out),
    .sys_finish (sys_finish)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int first_addr();
    return (addrs.size() > 0) ? addrs[0] : -1;
  endfunction

  function automatic int last_addr();
    return (addrs.size() > 0) ? addrs[addrs.size()-1] : -1;
  endfunction

  // cycle 0 is the negedge right after the edge that samples start
  task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1, input int budget);
    int cyc;
    addrs.delete();
    first_cyc = -1;
    last_cyc  = -1;
    fin_cyc   = -1;
    bad_col   = 0;
    @(negedge clk);
    x0 = 13'(ax0); y0 = 13'(ay0); x1 = 13'(ax1); y1 = 13'(ay1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    chk("fin_clr", int'(sys_finish), 0);
    while (cyc < budget) begin
      if (fb_we) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        addrs.push_back(int'(fb_addr));
        if (color_out !== 1'b1) bad_col++;
      end
      if (sys_finish) begin
        fin_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("finish_seen", int'(fin_cyc >= 0), 1);
  endtask

  initial begin
    int e, px, py, cx, cy, xdec;

    #12;
    chk("rst_we",   int'(fb_we), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_col",  int'(color_out), 0);
    chk("rst_fin",  int'(sys_finish), 0);
    @(negedge clk);
    reset = 1'b0;

    // diagonal
    draw(0, 0, 400, 400, 500);
    chk("diag_cnt",   addrs.size(), 401);
    chk("diag_first", first_addr(), 0);
    chk("diag_last",  last_addr(), 256400);
    chk("diag_col",   bad_col, 0);
    chk("diag_lat",   first_cyc, 2);
    chk("diag_fin",   fin_cyc, last_cyc + 1);
    e = 0;
    foreach (addrs[i]) if (addrs[i] != i * 641) e++;
    chk("diag_seq", e, 0);

    // steep, both directions negative
    draw(610, 410, 400, 10, 500);
    chk("steep_cnt",   addrs.size(), 401);
    chk("steep_first", first_addr(), 263010);
    chk("steep_last",  last_addr(), 6800);
    e = 0; xdec = 0;
    for (int i = 1; i < addrs.size(); i++) begin
      px = addrs[i-1] % 640; py = addrs[i-1] / 640;
      cx = addrs[i] % 640;   cy = addrs[i] / 640;
      if (cy != py - 1) e++;
      if (cx == px - 1) xdec++;
      else if (cx != px) e++;
    end
    chk("steep_step", e, 0);
    chk("steep_xdec", xdec, 210);

    // x decreasing, y increasing
    draw(610, 10, 300, 410, 500);
    chk("mix_cnt",   addrs.size(), 401);
    chk("mix_first", first_addr(), 7010);
    chk("mix_last",  last_addr(), 262700);
    e = 0;
    for (int i = 1; i < addrs.size(); i++) begin
      px = addrs[i-1] % 640; py = addrs[i-1] / 640;
      cx = addrs[i] % 640;   cy = addrs[i] / 640;
      if (cy != py + 1) e++;
      if (cx != px && cx != px - 1) e++;
    end
    chk("mix_step", e, 0);

    // horizontal
    draw(10, 210, 610, 210, 700);
    chk("hor_cnt", addrs.size(), 601);
    e = 0;
    foreach (addrs[i]) if (addrs[i] != 134410 + i) e++;
    chk("hor_seq", e, 0);
    chk("hor_fin", fin_cyc, 603);

    // degenerate point, then finish holds
    draw(5, 5, 5, 5, 20);
    chk("deg_cnt",  addrs.size(), 1);
    chk("deg_addr", first_addr(), 3205);
    chk("deg_lat",  first_cyc, 2);
    chk("deg_fin",  fin_cyc, 3);
    repeat (5) @(negedge clk);
    chk("deg_hold_fin",  int'(sys_finish), 1);
    chk("deg_hold_we",   int'(fb_we), 0);
    chk("deg_hold_addr", int'(fb_addr), 3205);

    // reset in the middle of a line
    @(negedge clk);
    x0 = 13'd0; y0 = 13'd0; x1 = 13'd400; y1 = 13'd400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_we", int'(fb_we), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we",   int'(fb_we), 0);
    chk("mid_rst_addr", int'(fb_addr), 0);
    chk("mid_rst_fin",  int'(sys_finish), 0);
    @(negedge clk);
    reset = 1'b0;
    e = 0;
    repeat (20) begin
      @(negedge clk);
      if (fb_we !== 1'b0) e++;
    end
    chk("post_rst_quiet", e, 0);

    // restart after reset: (1,1)->(4,2) visits (1,1),(2,1),(3,2),(4,2)
    draw(1, 1, 4, 2, 20);
    chk("re_cnt", addrs.size(), 4);
    chk("re_a0", addrs.size() > 0 ? addrs[0] : -1, 641);
    chk("re_a1", addrs.size() > 1 ? addrs[1] : -1, 642);
    chk("re_a2", addrs.size() > 2 ? addrs[2] : -1, 1283);
    chk("re_a3", addrs.size() > 3 ? addrs[3] : -1, 1284);

    // clipping past the right edge
    draw(630, 0, 650, 0, 50);
    chk("clip_cnt",   addrs.size(), 10);
    chk("clip_first", first_addr(), 630);
    chk("clip_last",  last_addr(), 639);
    chk("clip_fin",   fin_cyc, 23);
    chk("clip_col",   bad_col, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_drawing_core.md
Name: line_drawing_core

Overview:
- Hardware line rasteriser for the GPU line-drawing stage.
- Takes two endpoint coordinates and runs integer Bresenham over all octants, emitting one frame-buffer write per cycle.
- Each write carries a linear pixel address and a 1-bit colour.
- Sits between the vertex/primitive setup logic and a 640x480 monochrome frame buffer. Signals completion with a sticky finish flag.

Parameters:
- WIDTH, 13, bit width of each coordinate input.
- H_RES, 640, horizontal resolution; row pitch for address generation.
- V_RES, 480, vertical resolution; used for clipping.
- ADDR_W, 19, frame-buffer address width (640*480 = 307200 < 2^19).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; latches endpoints and begins drawing.
- x0  input  WIDTH  start point x, unsigned.
- y0  input  WIDTH  start point y, unsigned.
- x1  input  WIDTH  end point x, unsigned.
- y1  input  WIDTH  end point y, unsigned.
- FB_WE  output  1  frame-buffer write enable, one pixel per high cycle.
- FB_addr  output  ADDR_W  pixel address = y*H_RES + x.
- color_out  output  1  pixel colour; 1 (white) on every write.
- sys_finish  output  1  high once the line is complete; held high.

Behaviour:
- One clock; reset asynchronous active-high. While reset=1 or on assertion:
  - state=IDLE;
  - FB_WE=0, FB_addr=0, color_out=0, sys_finish=0;
  - all internal registers cleared.
- States: IDLE, INIT, DRAW, DONE. All outputs registered.
- IDLE -> INIT when start=1 at a rising edge; x0,y0,x1,y1 latched at that edge.
- INIT (1 cycle), computed from the latched endpoints:
  - dx = |x1-x0|; dy = -|y1-y0|;
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1;
  - err = dx+dy, signed, WIDTH+2 bits;
  - current point (x,y) = (x0,y0).
  - Then go to DRAW.
- DRAW, one pixel per cycle:
  - Present (x,y): FB_WE=1, color_out=1, FB_addr = y*640+x. Computed as (y<<9)+(y<<7)+x, truncated to ADDR_W.
  - If x==x1 and y==y1: go to DONE next edge.
  - Otherwise, with e2 = 2*err: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates may occur in the same cycle (diagonal step).
- Endpoints are inclusive. Pixel count = max(|x1-x0|,|y1-y0|)+1.
- First FB_WE occurs 2 cycles after the edge that samples start. FB_WE is contiguous until the last pixel.
- Clipping: if x>=H_RES or y>=V_RES, FB_WE=0 and color_out=0 for that cycle. Stepping and the cycle count are unchanged.
- DONE:
  - FB_WE=0, color_out=0, sys_finish=1 (held).
  - start=1 in DONE clears sys_finish, latches new endpoints and goes to INIT.
- start is ignored in INIT and DRAW.
- Degenerate line (x0==x1, y0==y1): exactly one write, then DONE.
- Reset mid-DRAW: immediate abort to IDLE, outputs cleared. No further writes until the next start.
- FB_addr holds its last value when FB_WE=0, except after reset (0).

Test Plan:
- Diagonal: reset; start with (0,0)->(400,400) -> 401 writes; addresses 0, 641, 1282, ... 256400; color_out=1 on each; sys_finish rises the cycle after the last write.
- Steep reverse: (610,410)->(400,10) -> 401 writes; first address 263010, last 6800; y decreases by 1 every write; x decreases 210 times in total.
- Mixed direction: (610,10)->(300,410) -> 401 writes; first address 7010, last 262700; each step moves x by 0 or -1 and y by +1.
- Horizontal: (10,210)->(610,210) -> 601 writes; consecutive addresses 134410..135010; then sys_finish=1.
- Degenerate and latency: (5,5)->(5,5) -> exactly one write at address 3205, first FB_WE 2 cycles after start; sys_finish stays high until the next start.
- Reset and restart: assert reset mid-DRAW -> FB_WE, FB_addr and sys_finish go to 0 immediately; a new start draws correctly. Clipping: (630,0)->(650,0) -> only x=630..639 written (10 writes), 21 DRAW cycles.
